imem_loader: RTL

Boot-time loader that fills the CPU's instruction memory from a byte stream. It receives bytes over a valid/ready handshake, packs them big-endian into 32-bit words, and writes them to consecutive instruction-memory word addresses. It holds the CPU in reset-equivalent stall (PC write-enable gated low) until a complete image has been written. It sits beside the instruction memory as its write port; the core's fetch path remains the read port.

---
 rtl/imem_loader_pkg.sv | 17 +
 rtl/imem_loader_byte_packer.sv | 34 +++
 rtl/imem_loader.sv | 102 ++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and widths for the boot-time instruction-memory loader.
package imem_loader_pkg;

  localparam int unsigned LEN_W  = 16;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_HI = 3'd1,
    LEN_LO = 3'd2,
    DATA   = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
  } state_e;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs a byte stream big-endian into 32-bit words; the 4th byte completes a word.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              clr,
  input  logic              i_clear,
  input  logic              i_strobe,
  input  logic [BYTE_W-1:0] i_byte,
  output logic              o_word_valid_c,
  output logic [WORD_W-1:0] o_word_c
);

  logic [23:0] r_shift;
  logic [1:0]  r_cnt;

  // Earlier bytes shift up so the first byte of a word ends in [31:24].
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_shift <= 24'd0;
      r_cnt   <= 2'd0;
    end else if (i_clear) begin
      r_shift <= 24'd0;
      r_cnt   <= 2'd0;
    end else if (i_strobe) begin
      r_shift <= {r_shift[15:0], i_byte};
      r_cnt   <= r_cnt + 2'd1;
    end
  end

  assign o_word_valid_c = i_strobe && (r_cnt == 2'd3);
  assign o_word_c       = {r_shift, i_byte};

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory write port fed from a length-prefixed byte stream;
// holds the CPU stalled until a complete image has been written.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_waddr,
  output logic [31:0]       im_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned CAP   = 1 << ADDR_W;

  state_e             r_state;
  state_e             w_state_next;
  logic [BYTE_W-1:0]  r_len_hi;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   w_len;
  logic               w_xfer;
  logic               w_start_ok;
  logic               w_last;
  logic               w_word_valid;
  logic [WORD_W-1:0]  w_word;

  assign w_len      = {r_len_hi, byte_data};
  assign byte_ready = (r_state == LEN_HI) || (r_state == LEN_LO) || (r_state == DATA);
  assign w_xfer     = byte_valid && byte_ready;
  assign w_start_ok = start && ((r_state == IDLE) || (r_state == DONE) || (r_state == ERR));
  assign w_last     = (32'(words_loaded) + 32'd1) == 32'(r_len);

  assign cpu_hold = (r_state != DONE);
  assign done     = (r_state == DONE);
  assign err      = (r_state == ERR);

  byte_packer u_packer (
    .clk            (clk),
    .clr            (clr),
    .i_clear        (w_start_ok),
    .i_strobe       (w_xfer && (r_state == DATA)),
    .i_byte         (byte_data),
    .o_word_valid_c (w_word_valid),
    .o_word_c       (w_word)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE, DONE, ERR: if (start) w_state_next = LEN_HI;
      LEN_HI:          if (w_xfer) w_state_next = LEN_LO;
      LEN_LO: begin
        if (w_xfer) begin
          if (w_len == LEN_W'(0))     w_state_next = DONE;
          else if (32'(w_len) > CAP)  w_state_next = ERR;
          else                        w_state_next = DATA;
        end
      end
      DATA:    if (w_word_valid && w_last) w_state_next = DONE;
      default: w_state_next = IDLE;
    endcase
  end

  // Length capture and the registered write port.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_len_hi     <= '0;
      r_len        <= '0;
      im_we        <= 1'b0;
      im_waddr     <= '0;
      im_wdata     <= '0;
      words_loaded <= '0;
    end else begin
      im_we <= 1'b0;
      if (w_start_ok) words_loaded <= '0;
      if (w_xfer && (r_state == LEN_HI)) r_len_hi <= byte_data;
      if (w_xfer && (r_state == LEN_LO)) r_len    <= w_len;
      if (w_word_valid) begin
        im_we        <= 1'b1;
        im_waddr     <= words_loaded[ADDR_W-1:0];
        im_wdata     <= w_word;
        words_loaded <= words_loaded + CNT_W'(1);
      end
    end
  end

endmodule
